next_pc_unit: RTL
=================

# next_pc_unit

Next-PC generator and fetch-request issuer for the RV32I core. It consumes the EX-stage taken decision and target address from the jump/branch control logic and owns the architectural PC. It issues instruction-fetch requests over a valid/ready handshake. Each request carries an epoch tag, so downstream stages can discard wrong-path instructions after a redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0000_0100, redirect address for a misaligned target (used only with the macro below)

Ports:
- i_Clk_1  in  1  core clock; all state changes on the rising edge
- i_Rst_1  in  1  reset, synchronous, active-high
- i_JumpBranch_1  in  1  taken jump/branch from EX, valid for one cycle
- i_Target_32  in  32  jump/branch target; sampled when i_JumpBranch_1=1
- i_Stall_1  in  1  pipeline hold; no new request is issued while 1
- i_FetchReady_1  in  1  instruction memory accepts the request
- o_FetchValid_1  out  1  fetch request valid
- o_FetchAddr_32  out  32  fetch address
- o_FetchEpoch_2  out  2  epoch tag attached to the request
- o_Epoch_2  out  2  current epoch; downstream drops any instruction whose tag differs
- o_Flush_1  out  1  one-cycle pulse that kills the IF/ID register
- o_Misaligned_1  out  1  one-cycle pulse on a misaligned target (with the macro only)

## Operation
- State machine with three states:
  - BOOT: entered on reset.
  - RUN: normal fetch.
  - PEND: a redirect is captured while the current request is not yet accepted.
- Registers:
  - PC (32 bits)
  - epoch (2 bits)
  - pending target (32 bits)
  - valid flag
- BOOT:
  - o_FetchValid_1=0, PC=RESET_PC.
  - Next cycle goes to RUN.
  - A redirect arriving in BOOT loads PC=target and increments the epoch. No flush pulse.
- RUN:
  - o_FetchValid_1 = valid flag.
  - Request is accepted when valid=1 and ready=1; PC becomes PC+4 (mod 2^32).
  - While i_Stall_1=1, no new request is raised after an acceptance. An already-raised request stays valid.
- Handshake rules:
  - Once o_FetchValid_1=1, o_FetchAddr_32 and o_FetchEpoch_2 stay stable until accepted.
  - o_FetchValid_1 does not drop before acceptance.
  - Reset is the only exception to both rules.
- Redirect in RUN (i_JumpBranch_1=1):
  - epoch increments (mod 4).
  - o_Flush_1=1 in the following cycle.
  - If no request is outstanding, or the outstanding request is accepted in this same cycle: PC=target, stay in RUN.
  - Otherwise: store the target and go to PEND.
- PEND:
  - The stale request completes unchanged, keeping its old epoch.
  - On acceptance: PC=pending target, go to RUN. The next request uses the new epoch.
  - A further redirect in PEND overwrites the pending target and increments the epoch again. Latest redirect wins.
- Redirect takes priority over stall: the redirect is captured even when i_Stall_1=1.
- Outstanding unaccepted requests are never more than 1, so a 2-bit epoch cannot alias.

## Timing
- Reset values (cycle after i_Rst_1=1 is sampled):
  - o_FetchValid_1=0
  - o_FetchAddr_32=RESET_PC
  - o_FetchEpoch_2=0, o_Epoch_2=0
  - o_Flush_1=0, o_Misaligned_1=0
  - state=BOOT
- First request: o_FetchValid_1=1 on the second cycle after reset is released.
- Reset asserted mid-operation drops any outstanding request immediately. The pending target is discarded.
- Redirect to target fetch:
  - From RUN: target request visible 1 cycle after the redirect cycle.
  - From PEND: 1 cycle after the stale request is accepted.
- Back-to-back acceptance: with ready held high and no stall, one request per cycle.
- o_Flush_1 and o_Misaligned_1 are registered single-cycle pulses.

## Configuration
- Macro: RV32_MISALIGN_TRAP_EN
- Defined:
  - A taken target with bits [1:0] != 0 pulses o_Misaligned_1 alongside o_Flush_1.
  - The redirect goes to TRAP_VECTOR instead of the target.
  - Epoch and flush behave as for a normal redirect.
- Undefined:
  - Target bits [1:0] are forced to 0.
  - o_Misaligned_1 is tied 0.

## Test plan
- Reset release with ready=1 -> addresses 0x0, 0x4, 0x8 on consecutive cycles, epoch 0.
- At PC 0x8, redirect to 0x40 with ready=1 -> o_Flush_1 pulse, next address 0x40, epoch 1.
- Request at 0xC held with ready=0, then redirect to 0x80 -> 0xC stays stable with epoch 0 until ready. Then 0x80 is issued with epoch 1.
- Two redirects (0x100, then 0x200) while in PEND -> 0x200 is issued with epoch 2; 0x100 is never issued.
- Stall=1 together with a redirect to 0x300 -> no request while stalled. After stall release the first address is 0x300.
- Redirect to 0x42 -> macro defined: o_Misaligned_1=1 and next address 0x100. Macro undefined: next address 0x40.

Source files
------------

// File: rtl/next_pc_unit.sv
// Next-PC generator: owns the architectural PC and issues epoch-tagged fetch requests.
// Optional macro RV32_MISALIGN_TRAP_EN sends misaligned jump/branch targets to TRAP_VECTOR.
module next_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        i_Clk_1,
    input  logic        i_Rst_1,
    input  logic        i_JumpBranch_1,
    input  logic [31:0] i_Target_32,
    input  logic        i_Stall_1,
    input  logic        i_FetchReady_1,
    output logic        o_FetchValid_1,
    output logic [31:0] o_FetchAddr_32,
    output logic [1:0]  o_FetchEpoch_2,
    output logic [1:0]  o_Epoch_2,
    output logic        o_Flush_1,
    output logic        o_Misaligned_1
);

    typedef enum logic [1:0] {BOOT, RUN, PEND} pcStateT;

    pcStateT     state, nextState;
    logic [31:0] pc, nextPc;
    logic [31:0] pendTarget, nextPendTarget;
    logic [1:0]  epoch, nextEpoch;
    logic [1:0]  reqEpoch, nextReqEpoch;
    logic        validFlag, nextValid;
    logic        flushReg, nextFlush;
    logic        misReg, nextMis;
    logic        accept;
    logic        targetMis;
    logic [31:0] effTarget;

`ifdef RV32_MISALIGN_TRAP_EN
    assign targetMis = (i_Target_32[1:0] != 2'b00);
    assign effTarget = targetMis ? TRAP_VECTOR : i_Target_32;
`else
    logic [33:0] unusedBits;
    assign unusedBits = {i_Target_32[1:0], TRAP_VECTOR};
    assign targetMis  = 1'b0;
    assign effTarget  = {i_Target_32[31:2], 2'b00};
`endif

    assign accept = validFlag & i_FetchReady_1;

    always_ff @(posedge i_Clk_1) begin
        if (i_Rst_1) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pendTarget <= '0;
            epoch      <= '0;
            reqEpoch   <= '0;
            validFlag  <= 1'b0;
            flushReg   <= 1'b0;
            misReg     <= 1'b0;
        end else begin
            state      <= nextState;
            pc         <= nextPc;
            pendTarget <= nextPendTarget;
            epoch      <= nextEpoch;
            reqEpoch   <= nextReqEpoch;
            validFlag  <= nextValid;
            flushReg   <= nextFlush;
            misReg     <= nextMis;
        end
    end

    // pc holds the outstanding request address, or the next one to raise when idle
    always_comb begin
        nextState      = state;
        nextPc         = pc;
        nextPendTarget = pendTarget;
        nextEpoch      = epoch;
        nextReqEpoch   = reqEpoch;
        nextValid      = validFlag;
        nextFlush      = 1'b0;
        nextMis        = 1'b0;

        if (i_JumpBranch_1) begin
            nextEpoch = epoch + 2'd1;
            nextMis   = targetMis;
        end

        case (state)
            BOOT: begin
                nextState    = RUN;
                nextValid    = ~i_Stall_1;
                nextReqEpoch = nextEpoch;
                if (i_JumpBranch_1) begin
                    nextPc = effTarget;
                end
            end
            RUN: begin
                if (i_JumpBranch_1) begin
                    nextFlush = 1'b1;
                    if (!validFlag || accept) begin
                        nextPc       = effTarget;
                        nextValid    = ~i_Stall_1;
                        nextReqEpoch = nextEpoch;
                    end else begin
                        nextPendTarget = effTarget;
                        nextState      = PEND;
                    end
                end else if (accept) begin
                    nextPc       = pc + 32'd4;
                    nextValid    = ~i_Stall_1;
                    nextReqEpoch = epoch;
                end else if (!validFlag) begin
                    nextValid    = ~i_Stall_1;
                    nextReqEpoch = epoch;
                end
            end
            PEND: begin
                // the stale request drains untouched; the latest redirect wins
                if (i_JumpBranch_1) begin
                    nextFlush      = 1'b1;
                    nextPendTarget = effTarget;
                end
                if (accept) begin
                    nextPc       = i_JumpBranch_1 ? effTarget : pendTarget;
                    nextState    = RUN;
                    nextValid    = ~i_Stall_1;
                    nextReqEpoch = nextEpoch;
                end
            end
            default: begin
                nextState = BOOT;
                nextValid = 1'b0;
            end
        endcase
    end

    assign o_FetchValid_1 = validFlag;
    assign o_FetchAddr_32 = pc;
    assign o_FetchEpoch_2 = reqEpoch;
    assign o_Epoch_2      = epoch;
    assign o_Flush_1      = flushReg;
    assign o_Misaligned_1 = misReg;

endmodule
